// File: rtl/bin_to_bcd_four.sv
// Sequential 14-bit binary to four-digit BCD converter (double dabble, one bit per cycle).
// Inputs above 9999 saturate the display to 9999 and raise overflow.
module bin_to_bcd_four (
  input  logic       clk,
  input  logic       rst,
  input  logic [13:0] bin_in,
  input  logic       start,
  output logic [3:0] d4,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  localparam int unsigned BIN_W     = 14;
  localparam int unsigned BCD_W     = 16;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned LAST_ITER = BIN_W - 1;
  localparam int unsigned MAX_DEC   = 9999;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [BIN_W-1:0] shift_q;
  logic [BCD_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;

  logic [BCD_W-1:0] acc_adj;
  logic [BCD_W-1:0] acc_next;
  logic [BIN_W-1:0] shift_next;

  // One double-dabble step: add 3 to nibbles >= 5, then shift {acc, shift} left.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_next   = BCD_W'({acc_adj, shift_q[BIN_W-1]});
    shift_next = {shift_q[BIN_W-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      d4       <= '0;
      d3       <= '0;
      d2       <= '0;
      d1       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_q <= bin_in;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= (bin_in > BIN_W'(MAX_DEC));
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q   <= acc_next;
          shift_q <= shift_next;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LAST_ITER)) begin
            // Digits only change here, so partial accumulator values never reach the outputs.
            if (sat_q) begin
              {d4, d3, d2, d1} <= 16'h9999;
            end else begin
              {d4, d3, d2, d1} <= acc_next;
            end
            overflow <= sat_q;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_four.sv
// Self-checking bench for bin_to_bcd_four: directed corner cases plus random values
// compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd_four;

  logic        clk;
  logic        rst;
  logic [13:0] bin_in;
  logic        start;
  logic [3:0]  d4, d3, d2, d1;
  logic        busy, done, overflow;

  int checks;
  int errors;

  logic [15:0] exp_digits;
  logic        exp_ovf;

  bin_to_bcd_four dut (
    .clk      (clk),
    .rst      (rst),
    .bin_in   (bin_in),
    .start    (start),
    .d4       (d4),
    .d3       (d3),
    .d2       (d2),
    .d1       (d1),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Decimal digits of the value, saturated at 9999.
  function automatic logic [15:0] ref_bcd(input int n);
    int m;
    m = (n > 9999) ? 9999 : n;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Start a conversion and watch 20 cycles; optionally pulse start (with junk data)
  // one cycle so that it lands on edge E(inject+1).
  task automatic run_conv(input int v, input int inject, input string tag);
    int busy_cnt;
    int done_cnt;
    int done_cyc;
    int early_changes;
    logic [15:0] nd;
    logic        novf;
    busy_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
    early_changes = 0;
    nd   = ref_bcd(v);
    novf = (v > 9999);
    @(negedge clk);
    bin_in = 14'(v);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 14'($urandom);
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        check({tag, " digits"}, 32'({d4, d3, d2, d1}), 32'(nd));
        check({tag, " overflow"}, 32'(overflow), 32'(novf));
      end else if (cyc < 14) begin
        if ({d4, d3, d2, d1} !== exp_digits || overflow !== exp_ovf) early_changes++;
      end
      if (cyc == inject) begin
        start  = 1'b1;
        bin_in = 14'd1111;
      end else begin
        start  = 1'b0;
        bin_in = 14'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'd14);
    check({tag, " done count"}, 32'(done_cnt), 32'd1);
    check({tag, " done latency"}, 32'(done_cyc), 32'd14);
    check({tag, " outputs held"}, 32'(early_changes), 32'd0);
    exp_digits = nd;
    exp_ovf    = novf;
  endtask

  initial begin
    int last_done;
    int pulses;
    int bad_gaps;
    int bad_vals;
    int stray_done;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = 14'd0;
    repeat (3) @(negedge clk);
    check("reset digits", 32'({d4, d3, d2, d1}), 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    exp_digits = 16'h0;
    exp_ovf    = 1'b0;

    run_conv(1234, -1, "1234");
    run_conv(0, -1, "0");
    run_conv(9999, -1, "9999");
    run_conv(1000, -1, "1000");
    run_conv(12000, -1, "12000");
    run_conv(42, -1, "42");
    run_conv(10000, -1, "10000");
    run_conv(16383, -1, "16383");
    run_conv(5678, 4, "5678 start-while-busy");

    // Continuous start: conversions repeat every 15 cycles.
    @(negedge clk);
    bin_in = 14'd7;
    start  = 1'b1;
    last_done = -1;
    pulses    = 0;
    bad_gaps  = 0;
    bad_vals  = 0;
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (last_done >= 0 && cyc - last_done != 15) bad_gaps++;
        if ({d4, d3, d2, d1} !== 16'h0007 || overflow !== 1'b0) bad_vals++;
        last_done = cyc;
      end
    end
    start = 1'b0;
    check("hold-start pulses", 32'(pulses >= 4), 32'd1);
    check("hold-start period", 32'(bad_gaps), 32'd0);
    check("hold-start digits", 32'(bad_vals), 32'd0);
    repeat (20) @(negedge clk);
    exp_digits = 16'h0007;
    exp_ovf    = 1'b0;

    // Reset at E7 aborts the 0321 conversion.
    @(negedge clk);
    bin_in = 14'd321;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort digits", 32'({d4, d3, d2, d1}), 32'h0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort overflow", 32'(overflow), 32'd0);
    stray_done = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (done || busy) stray_done++;
      @(negedge clk);
    end
    check("abort no done", 32'(stray_done), 32'd0);
    exp_digits = 16'h0;
    exp_ovf    = 1'b0;
    run_conv(321, -1, "0321 after reset");

    for (int k = 0; k < 25; k++) begin
      run_conv(int'($urandom_range(0, 16383)), -1, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_four.md
BIN_TO_BCD_FOUR -- requirements
Module: bin_to_bcd_four

Interface
REQ-001 The block SHALL have no parameters; the binary input width is fixed at 14 bits and the output is fixed at four BCD digits.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 bin_in  input  14  unsigned binary value, sampled only when start is accepted.
REQ-006 start  input  1  conversion request, level-sampled on each rising edge.
REQ-007 d4  output  4  thousands BCD digit, registered; drives the display mux thousands digit.
REQ-008 d3  output  4  hundreds BCD digit, registered.
REQ-009 d2  output  4  tens BCD digit, registered.
REQ-010 d1  output  4  units BCD digit, registered.
REQ-011 busy  output  1  high while a conversion is in progress.
REQ-012 done  output  1  one-cycle pulse marking new digit values.
REQ-013 overflow  output  1  high when the last accepted bin_in exceeded 9999.

Function
REQ-014 The FSM SHALL have exactly two states.
- IDLE: waiting for start.
- SHIFT: conversion in progress.
REQ-015 In IDLE, start=1 at rising edge E0 SHALL accept the request.
- Capture bin_in into the shift register.
- Clear the 16-bit BCD accumulator and the 4-bit iteration counter.
- Enter SHIFT; busy=1 after E0.
REQ-016 Each SHIFT cycle SHALL perform one double-dabble iteration, MSB of the captured value first.
- Add 3 to every accumulator nibble whose value is >= 5.
- Then shift {accumulator, shift register} left by one bit.
REQ-017 Exactly 14 iterations SHALL occur, at edges E1..E14.
REQ-018 At E14 the block SHALL:
- write the accumulator to d4..d1 (d4 = most significant nibble);
- set done=1 for exactly one cycle;
- clear busy;
- return to IDLE.
REQ-019 Latency SHALL be fixed.
- busy is high for exactly 14 cycles.
- done is visible in the cycle following E14, independent of the input value.
REQ-020 d4..d1 SHALL hold their values between conversions and SHALL NOT change at any edge other than E14 or reset; intermediate accumulator values are never visible.
REQ-021 Saturation: if the captured value is >9999, then at E14:
- d4..d1 SHALL be 9,9,9,9;
- overflow SHALL be 1.
REQ-022 If the captured value is <=9999, overflow SHALL be 0 at E14.
REQ-023 overflow SHALL hold its value until the next E14 or reset.
REQ-024 start while busy=1 SHALL be ignored: no restart, no queueing, no effect on the captured value.
REQ-025 start=1 in the same cycle that done=1 SHALL be accepted, because the block is already in IDLE; back-to-back conversions therefore repeat every 15 cycles.
REQ-026 bin_in changes while busy=1 SHALL NOT affect the result.
REQ-027 Every d output SHALL always hold a legal BCD value (0..9).

Reset
REQ-028 When rst=1 at a rising edge, the following SHALL take effect after that edge, and rst SHALL have priority over start:
- state=IDLE;
- d4..d1=0;
- busy=0, done=0, overflow=0;
- counter, shift register and accumulator = 0.
REQ-029 Reset during SHIFT SHALL abort the conversion; no done pulse and no digit update SHALL follow.
REQ-030 After rst is released, the first start SHALL be accepted normally.

Verification
REQ-031 bin_in=1234, start pulse at E0:
- busy=1 for 14 cycles;
- after E14: d4..d1=1,2,3,4, done=1 for one cycle, overflow=0.
REQ-032 bin_in=0 -> 0,0,0,0. bin_in=9999 -> 9,9,9,9 with overflow=0. bin_in=1000 -> 1,0,0,0.
REQ-033 bin_in=12000 -> 9,9,9,9 with overflow=1; then bin_in=42 -> 0,0,4,2 with overflow=0.
REQ-034 Convert 5678. At E5 assert start with bin_in=1111 while busy:
- the result is still 5,6,7,8;
- exactly one done pulse occurs.
REQ-035 Hold start=1 continuously with bin_in=0007:
- done pulses every 15 cycles;
- outputs read 0,0,0,7.
REQ-036 Convert 0321. Assert rst at E7:
- after E7: all outputs 0, busy=0;
- no done pulse follows;
- a new start with bin_in=0321 yields 0,3,2,1.
